fmap_buffer: RTL and testbench

Parametrised single-bank feature-map buffer for the convolution datapath. A producer writes one ROWS×COLS map of WIDTH-bit pixels in raster order. The buffer then drains it in raster order to the window/convolution stage. With padding compiled in, the drained frame carries a zero border of PAD pixels on every side. It replaces fixed-size 30×30 map storage and adds handshakes, frame sequencing and a clear.

---
 rtl/fmap_buffer.sv | 169 ++++++++++++++++
 tb/tb_fmap_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fmap_buffer.sv
// fmap_buffer
//   Single-bank feature-map buffer. A producer writes one ROWS x COLS map of
//   WIDTH-bit pixels in raster order (FILL). The stored map is then drained in
//   raster order to the window/convolution stage (DRAIN). When FMAP_PAD_EN is
//   defined, the drained frame is surrounded by a zero border PAD pixels thick.
//   Border pixels are generated on the fly and are never stored.
//
// Build option: `define FMAP_PAD_EN enables border generation. Without it, PAD
// is ignored and the drained frame is exactly ROWS x COLS.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous abort: back to FILL, the frame is discarded
//   in_valid  in   producer pixel valid
//   in_data   in   producer pixel [WIDTH]
//   in_ready  out  buffer accepts a pixel (FILL)
//   out_valid out  drained pixel valid (DRAIN)
//   out_data  out  drained pixel [WIDTH], zero in the border
//   out_ready in   consumer accepts a pixel
//   out_eol   out  last pixel of an output row (qualified by out_valid)
//   out_last  out  last pixel of the frame (qualified by out_valid)
//   full      out  frame complete, buffer is draining
module fmap_buffer #(
  parameter int WIDTH = 9,
  parameter int ROWS  = 30,
  parameter int COLS  = 30,
  parameter int PAD   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             out_last,
  output logic             full
);

`ifdef FMAP_PAD_EN
  localparam int OR = ROWS + 2 * PAD;
  localparam int OC = COLS + 2 * PAD;
`else
  localparam int OR = ROWS;
  localparam int OC = COLS;
`endif

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int WRW   = $clog2(ROWS) + 1;
  localparam int WCW   = $clog2(COLS) + 1;
  localparam int RRW   = $clog2(OR) + 1;
  localparam int RCW   = $clog2(OC) + 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state;
  logic [WRW-1:0]   wr_row;
  logic [WCW-1:0]   wr_col;
  logic [RRW-1:0]   rd_row;
  logic [RCW-1:0]   rd_col;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             wr_en;
  logic             wr_final;
  logic             border;
  logic             row_end;
  logic             frame_end;

  assign wr_addr  = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
  assign wr_en    = in_valid && in_ready && !clear;
  assign wr_final = (wr_row == WRW'(ROWS - 1)) && (wr_col == WCW'(COLS - 1));

`ifdef FMAP_PAD_EN
  logic [RRW-1:0] src_row;
  logic [RCW-1:0] src_col;

  assign border  = (rd_row < RRW'(PAD)) || (rd_row >= RRW'(ROWS + PAD)) ||
                   (rd_col < RCW'(PAD)) || (rd_col >= RCW'(COLS + PAD));
  assign src_row = rd_row - RRW'(PAD);
  assign src_col = rd_col - RCW'(PAD);
  // Border pixels use a dummy address so the array index stays in range.
  assign rd_addr = border ? '0 : AW'(src_row) * AW'(COLS) + AW'(src_col);
`else
  assign border  = 1'b0;
  assign rd_addr = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
`endif

  assign row_end   = (rd_col == RCW'(OC - 1));
  assign frame_end = row_end && (rd_row == RRW'(OR - 1));

  // out_valid is only set in DRAIN, so it gates the read-side outputs to zero
  // in FILL and during reset.
  assign out_data = (out_valid && !border) ? mem[rd_addr] : '0;
  assign out_eol  = out_valid && row_end;
  assign out_last = out_valid && frame_end;

  // Storage is not reset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_row    <= '0;
      wr_col    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (clear) begin
      state     <= FILL;
      wr_row    <= '0;
      wr_col    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (wr_final) begin
              state     <= DRAIN;
              wr_row    <= '0;
              wr_col    <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              full      <= 1'b1;
            end else if (wr_col == WCW'(COLS - 1)) begin
              wr_col <= '0;
              wr_row <= wr_row + 1'b1;
            end else begin
              wr_col <= wr_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (frame_end) begin
              state     <= FILL;
              rd_row    <= '0;
              rd_col    <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              full      <= 1'b0;
            end else if (row_end) begin
              rd_col <= '0;
              rd_row <= rd_row + 1'b1;
            end else begin
              rd_col <= rd_col + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_buffer.sv
// tb_fmap_buffer
//   Directed self-checking bench for fmap_buffer with a 4x4 map. Geometry of
//   the expected drained frame follows FMAP_PAD_EN (PAD=1 when defined).
module tb_fmap_buffer;

`ifdef FMAP_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N   = 4;
  localparam int OCX = N + 2 * P;
  localparam int BEATS = OCX * OCX;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_data;
  logic       out_ready = 1'b0;
  logic       out_eol;
  logic       out_last;
  logic       full;

  int checks = 0;
  int failures = 0;

  logic [8:0] rec_data [BEATS];
  logic       rec_eol  [BEATS];
  logic       rec_last [BEATS];

  always #5 clk = ~clk;

  fmap_buffer #(.WIDTH(9), .ROWS(N), .COLS(N), .PAD(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_eol(out_eol), .out_last(out_last), .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {last, eol, data} for a beat of a frame holding base+1..base+16.
  function automatic logic [10:0] model(input int base, input int beat);
    int r, c, d;
    r = beat / OCX;
    c = beat % OCX;
    if (r < P || r >= N + P || c < P || c >= N + P) d = 0;
    else d = base + (r - P) * N + (c - P) + 1;
    return {(beat == BEATS - 1), (c == OCX - 1), d[8:0]};
  endfunction

  // Writes base+1..base+16 back-to-back; checks the buffer stays in FILL until
  // the 16th accept and enters DRAIN on the following cycle.
  task automatic fill(input int base);
    for (int i = 0; i < N * N; i++) begin
      @(negedge clk);
      chk("fill_ready", in_ready, 1);
      chk("fill_not_full", full, 0);
      in_valid = 1'b1;
      in_data  = 9'(base + i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_valid", out_valid, 1);
    chk("drain_full", full, 1);
    chk("drain_not_ready", in_ready, 0);
  endtask

  // Drains a whole frame. stall: random out_ready. junk: hold in_valid with
  // 0x1FF throughout, which must be refused.
  task automatic drain(input int base, input bit stall, input bit junk);
    int beat = 0;
    int budget = 0;
    logic [10:0] e;
    bit done = 0;
    while (!done && budget < 1000) begin
      budget++;
      if (budget > 1) @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 9'h1FF;
        chk("junk_refused", in_ready, 0);
      end
      e = model(base, beat);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, e[8:0]);
      chk("out_eol", out_eol, e[9]);
      chk("out_last", out_last, e[10]);
      rec_data[beat] = out_data;
      rec_eol[beat]  = out_eol;
      rec_last[beat] = out_last;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (out_ready) begin
        if (beat == BEATS - 1) done = 1;
        beat++;
      end
    end
    chk("drain_budget", done, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("turn_ready", in_ready, 1);
    chk("turn_valid", out_valid, 0);
    chk("turn_full", full, 0);
  endtask

  initial begin
    // Reset held with a producer pushing.
    in_valid = 1'b1;
    in_data  = 9'h055;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Basic frame; hand-computed beats.
    fill(0);
    @(negedge clk);
    drain(0, 1'b0, 1'b0);
`ifdef FMAP_PAD_EN
    chk("p_beat6", rec_data[6], 0);
    chk("p_beat7", rec_data[7], 1);
    chk("p_beat10", rec_data[10], 4);
    chk("p_beat11", rec_data[11], 0);
    chk("p_beat11_eol", rec_eol[11], 1);
    chk("p_beat28", rec_data[28], 16);
    chk("p_beat29", rec_data[29], 0);
    chk("p_beat35_last", rec_last[35], 1);
`else
    chk("u_beat0", rec_data[0], 1);
    chk("u_beat3", rec_data[3], 4);
    chk("u_beat3_eol", rec_eol[3], 1);
    chk("u_beat4_eol", rec_eol[4], 0);
    chk("u_beat15", rec_data[15], 16);
    chk("u_beat15_last", rec_last[15], 1);
    chk("u_beat14_last", rec_last[14], 0);
`endif

    // Backpressure.
    fill(100);
    drain(100, 1'b1, 1'b0);

    // Overlap rejection, then a second frame.
    fill(200);
    drain(200, 1'b0, 1'b1);
    fill(16);
    drain(16, 1'b0, 1'b0);

    // clear after 5 writes discards them; 16 more are needed.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9'(300 + i);
    end
    @(negedge clk);
    clear = 1'b1;
    in_data = 9'h1AA;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_full", full, 0);
    chk("clr_ready", in_ready, 1);
    fill(32);
    drain(32, 1'b0, 1'b0);

    // clear coinciding with the final input handshake wins.
    for (int i = 0; i < N * N; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9'(i + 1);
      if (i == N * N - 1) clear = 1'b1;
    end
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_last_full", full, 0);
    chk("clr_last_valid", out_valid, 0);
    chk("clr_last_ready", in_ready, 1);

    // Reset pulse mid-drain at beat 6.
    fill(50);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_data", out_data, 9'(model(50, 6)));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill(60);
    drain(60, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
